shift_sequencer: RTL and testbench

Multi-cycle 32-bit shift unit for the ALU's long-latency path. It applies the fixed-amount shift stages (16, 8, 4, 2, 1) one per cycle, each gated by the matching bit of the shift amount.
- Supports logical left shift (SLL) and arithmetic right shift (SRA).
- Uses a start/ready handshake compatible with the multdiv unit's ctrl/ready convention.
- The pipeline stall logic holds the instruction in X until data_ready pulses.

---
 rtl/shift_pkg.sv | 37 +++
 rtl/shift_stage_mux.sv | 25 ++
 rtl/shift_sequencer.sv | 125 ++++++++++++
 tb/tb_shift_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// Optional build macro: SHIFT_EARLY_DONE_EN (see shift_sequencer.sv).
package shift_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 5;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned EXT_W  = 8;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    localparam int unsigned STAGE_AMT_16 = 16;
    localparam int unsigned STAGE_AMT_8  = 8;
    localparam int unsigned STAGE_AMT_4  = 4;
    localparam int unsigned STAGE_AMT_2  = 2;
    localparam int unsigned STAGE_AMT_1  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Shift distance applied by stage index idx (2^idx); out-of-range indices shift by 0.
    function automatic int unsigned stage_amt(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd4:    return STAGE_AMT_16;
            3'd3:    return STAGE_AMT_8;
            3'd2:    return STAGE_AMT_4;
            3'd1:    return STAGE_AMT_2;
            3'd0:    return STAGE_AMT_1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/shift_stage_mux.sv
// One fixed-amount shift stage: SLL zero-fill or SRA sign-fill by 2^idx, or pass-through.
module shift_stage_mux
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] value_i,
    input  logic             op_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] sll_v;
    logic [WIDTH-1:0] sra_v;

    // Select the stage result; bits shifted out are dropped.
    always_comb begin
        sll_v   = value_i << stage_amt(idx_i);
        sra_v   = WIDTH'($signed(value_i) >>> stage_amt(idx_i));
        value_o = value_i;
        if (en_i) begin
            value_o = (op_i == OP_SRA) ? sra_v : sll_v;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: stages 16/8/4/2/1 applied one per cycle, start/ready handshake.
// Optional build macro: SHIFT_EARLY_DONE_EN -- skip trailing zero stages (variable latency).
module shift_sequencer
    import shift_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_start,
    input  logic              op,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [STAGES-1:0] shamt,
    output logic [WIDTH-1:0]  data_result,
    output logic              data_ready,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic              op_q, op_d;
    logic [STAGES-1:0] shamt_q, shamt_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic [EXT_W-1:0]  shamt_ext;
    logic              stage_en;
    logic              last_stage;
    logic              skip_shift;
    logic              accept;
    logic [WIDTH-1:0]  stage_out;

    assign shamt_ext = EXT_W'(shamt_q);
    assign stage_en  = (state_q == SHIFT) && shamt_ext[k_q];
    assign accept    = ctrl_start && ((state_q == IDLE) || (state_q == DONE));

`ifdef SHIFT_EARLY_DONE_EN
    logic [EXT_W-1:0] remaining;
    assign remaining  = shamt_ext & ((EXT_W'(1) << k_q) - EXT_W'(1));
    assign last_stage = (k_q == '0) || (remaining == '0);
    assign skip_shift = (shamt == '0);
`else
    assign last_stage = (k_q == '0);
    assign skip_shift = 1'b0;
`endif

    shift_stage_mux u_stage (
        .value_i (work_q),
        .op_i    (op_q),
        .en_i    (stage_en),
        .idx_i   (k_q),
        .value_o (stage_out)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            op_q    <= 1'b0;
            shamt_q <= '0;
            work_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            work_q  <= work_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: starts accepted in IDLE and DONE, ignored in SHIFT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    state_d = skip_shift ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_stage) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ctrl_start) begin
                    state_d = skip_shift ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for the datapath and the registered ready/busy outputs.
    always_comb begin
        k_d     = k_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        work_d  = work_q;
        ready_d = (state_d == DONE);
        busy_d  = (state_d == SHIFT);
        if (accept) begin
            work_d  = data_in;
            op_d    = op;
            shamt_d = shamt;
            k_d     = IDX_W'(STAGES - 1);
        end else if (state_q == SHIFT) begin
            work_d = stage_out;
            if (k_q != '0) begin
                k_d = k_q - IDX_W'(1);
            end
        end
    end

    assign data_result = work_q;
    assign data_ready  = ready_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: scoreboard of expected results and latencies.
module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [4:0]  shamt = 5'h0;
    logic [31:0] data_result;
    logic        data_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned lat;
        int unsigned t0;
    } exp_t;

    exp_t sb[$];

    shift_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .ctrl_start  (ctrl_start),
        .op          (op),
        .data_in     (data_in),
        .shamt       (shamt),
        .data_result (data_result),
        .data_ready  (data_ready),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: shift one bit at a time.
    function automatic logic [31:0] model_shift(input logic o, input logic [31:0] d, input logic [4:0] s);
        logic [31:0] x;
        x = d;
        for (int i = 0; i < int'(s); i++) begin
            x = o ? {x[31], x[31:1]} : {x[30:0], 1'b0};
        end
        return x;
    endfunction

    function automatic int unsigned model_lat(input logic [4:0] s);
`ifdef SHIFT_EARLY_DONE_EN
        if (s == 5'd0) return 1;
        for (int b = 0; b < 5; b++) begin
            if (s[b]) return 6 - b;
        end
        return 6;
`else
        return 6;
`endif
    endfunction

    // Scoreboard: compare every ready pulse with the oldest expected entry.
    always @(negedge clock) begin
        if (reset === 1'b1 && data_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_ready result=%h", data_result);
            end else begin
                exp_t e;
                int unsigned lat;
                e = sb.pop_front();
                lat = cyc - e.t0 + 1;
                checks++;
                if (data_result !== e.res) begin
                    errors++;
                    $display("FAIL sb_result got=%h exp=%h", data_result, e.res);
                end
                checks++;
                if (lat !== e.lat) begin
                    errors++;
                    $display("FAIL sb_latency got=%0d exp=%0d", lat, e.lat);
                end
            end
        end
    end

    // Called at a negedge; holds start for one posedge and returns at the following negedge.
    task automatic drive_start(input logic o, input logic [31:0] d, input logic [4:0] s);
        exp_t e;
        e.res = model_shift(o, d, s);
        e.lat = model_lat(s);
        e.t0  = cyc + 1;
        sb.push_back(e);
        op = o;
        data_in = d;
        shamt = s;
        ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (data_ready === 1'b1) got = 1'b1;
            else @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=%h", data_result, 32'h0); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_sra16();
        bit got;
        drive_start(1'b1, 32'h8000_0000, 5'd16);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL sra16_busy got=%b exp=1", busy); end
        wait_ready(12, got);
        checks++;
        if (!got) begin errors++; $display("FAIL sra16_timeout got=0 exp=1"); end
        @(negedge clock);
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL sra16_pulse_width got=%b exp=0", data_ready); end
        checks++;
        if (data_result !== 32'hFFFF_8000) begin errors++; $display("FAIL sra16_hold got=%h exp=%h", data_result, 32'hFFFF_8000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL sra16_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_sll_sra();
        bit got;
        drive_start(1'b0, 32'h0000_0001, 5'd31);
        wait_ready(12, got);
        checks++;
        if (!got) begin errors++; $display("FAIL sll31_timeout got=0 exp=1"); end
        @(negedge clock);
        drive_start(1'b1, 32'h7FFF_0000, 5'd5);
        wait_ready(12, got);
        checks++;
        if (!got) begin errors++; $display("FAIL sra5_timeout got=0 exp=1"); end
        @(negedge clock);
    endtask

    task automatic test_zero_shamt();
        bit got;
        drive_start(1'b0, 32'hDEAD_BEEF, 5'd0);
        wait_ready(12, got);
        checks++;
        if (!got) begin errors++; $display("FAIL zero_timeout got=0 exp=1"); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        bit got;
        drive_start(1'b0, 32'h0000_000F, 5'd4);
        @(negedge clock);
        op = 1'b1;
        data_in = 32'hAAAA_5555;
        shamt = 5'd3;
        ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got=%b exp=1", busy); end
        wait_ready(12, got);
        checks++;
        if (!got) begin errors++; $display("FAIL ignore_timeout got=0 exp=1"); end
        drive_start(1'b0, 32'h0000_1234, 5'd8);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got=%b exp=0", data_ready); end
        wait_ready(12, got);
        checks++;
        if (!got) begin errors++; $display("FAIL b2b_timeout got=0 exp=1"); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        bit got;
        int seen;
        drive_start(1'b1, 32'hF000_0000, 5'd8);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        void'(sb.pop_back());
        checks++;
        if (data_result !== 32'h0) begin errors++; $display("FAIL midrst_result got=%h exp=%h", data_result, 32'h0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", data_ready); end
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (data_ready !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_no_pulse got=%0d exp=0", seen); end
        drive_start(1'b1, 32'hF000_0000, 5'd8);
        wait_ready(12, got);
        checks++;
        if (!got) begin errors++; $display("FAIL midrst_fresh_timeout got=0 exp=1"); end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout reached=1 exp=0");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_sra16();
        test_sll_sra();
        test_zero_shamt();
        test_back_to_back();
        test_reset_mid();
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
